clk_en_ctrl: RTL and testbench

CLK_EN_CTRL -- requirements
Module: clk_en_ctrl

---
 rtl/clk_en_ctrl_pkg.sv | 16 +
 rtl/clk_en_counter.sv | 37 +++
 rtl/clk_en_ctrl.sv | 144 ++++++++++++++
 tb/tb_clk_en_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/clk_en_ctrl_pkg.sv
// Shared definitions for the clock-enable controller.
//   state_t    : FSM state encoding (IDLE, RUN, PEND), 2 bits
//   CNT_W_DEF  : default width of the divide-ratio / period counter
//   DEF_DIV_C  : default divide ratio loaded at reset (50 MHz -> 1 Hz)
package clk_en_ctrl_pkg;

  localparam int unsigned CNT_W_DEF = 28;
  localparam logic [27:0] DEF_DIV_C = 28'd50_000_000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

endpackage

// File: rtl/clk_en_counter.sv
// Loadable down-counter with terminal-count flag.
//   clk      : clock
//   rst      : asynchronous active-low reset (count -> 0)
//   load     : load load_val on the next edge (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one; saturates at zero instead of wrapping
//   cnt      : current count
//   tc       : terminal count, high while cnt == 0
module clk_en_counter
  import clk_en_ctrl_pkg::*;
#(
  parameter int CNT_W = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - ONE;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/clk_en_ctrl.sv
// Clock-enable controller: produces a one-cycle tick every `active` clk
// cycles while running, plus an LED square wave toggling on every tick.
// A new ratio offered while running is held in a shadow register and only
// takes effect once the current period has completed.
//   clk       : single clock, no derived clocks
//   rst       : asynchronous active-low reset
//   cfg_valid : cfg_div carries a new divide ratio
//   cfg_div   : divide ratio in clk cycles per tick (0 behaves as 1)
//   cfg_ready : a ratio can be accepted this cycle (low while one is pending)
//   start     : begin ticking (ignored while already running)
//   stop      : halt ticking (wins over start)
//   tick      : registered one-cycle clock-enable pulse
//   led       : toggles on every tick
//   running   : high in RUN and PEND
module clk_en_ctrl
  import clk_en_ctrl_pkg::*;
#(
  parameter int               CNT_W   = 28,
  parameter logic [CNT_W-1:0] DEF_DIV = DEF_DIV_C
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic             led,
  output logic             running
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // Ratios 0 and 1 both mean "tick every cycle"; keeps reloads >= 1.
  function automatic logic [CNT_W-1:0] eff_ratio(input logic [CNT_W-1:0] d);
    return (d == '0) ? ONE : d;
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] active, active_nxt;
  logic [CNT_W-1:0] shadow, shadow_nxt;
  logic [CNT_W-1:0] cnt, cnt_val;
  logic             cnt_ld, cnt_dec, cnt_tc;
  logic             tick_nxt;
  logic             xfer;
  logic [CNT_W-1:0] eff;

  assign xfer = cfg_valid && cfg_ready;
  assign eff  = eff_ratio(cfg_div);

  clk_en_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_ld),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_nxt  = state;
    active_nxt = active;
    shadow_nxt = shadow;
    cnt_ld     = 1'b0;
    cnt_val    = '0;
    cnt_dec    = 1'b0;
    tick_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) active_nxt = eff;
        if (stop) begin
          cnt_ld = 1'b1;
        end else if (start) begin
          state_nxt = RUN;
          cnt_ld    = 1'b1;
          cnt_val   = active - ONE;
        end
      end
      RUN: begin
        if (stop) begin
          // A ratio arriving with stop is committed straight to active.
          if (xfer) active_nxt = eff;
          state_nxt = IDLE;
          cnt_ld    = 1'b1;
        end else begin
          if (cnt_tc) begin
            tick_nxt = 1'b1;
            cnt_ld   = 1'b1;
            cnt_val  = active - ONE;
          end else begin
            cnt_dec = 1'b1;
          end
          if (xfer) begin
            shadow_nxt = eff;
            state_nxt  = PEND;
          end
        end
      end
      PEND: begin
        if (stop) begin
          // Commit the pending ratio so it survives the stop.
          active_nxt = shadow;
          state_nxt  = IDLE;
          cnt_ld     = 1'b1;
        end else if (cnt_tc) begin
          tick_nxt   = 1'b1;
          active_nxt = shadow;
          cnt_ld     = 1'b1;
          cnt_val    = shadow - ONE;
          state_nxt  = RUN;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_ld    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      active    <= DEF_DIV;
      shadow    <= DEF_DIV;
      tick      <= 1'b0;
      led       <= 1'b0;
      running   <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      state     <= state_nxt;
      active    <= active_nxt;
      shadow    <= shadow_nxt;
      tick      <= tick_nxt;
      if (tick_nxt) led <= ~led;
      running   <= (state_nxt != IDLE);
      cfg_ready <= (state_nxt != PEND);
    end
  end

endmodule

// File: tb/tb_clk_en_ctrl.sv
// Directed bench for clk_en_ctrl. Inputs change on the falling edge and
// outputs are sampled on the falling edge after each rising edge. Edge 0 of
// each sequence is the rising edge that samples start. DEF_DIV is reduced
// to 6 so the post-reset ratio can be observed in a short run.
module tb_clk_en_ctrl;

  localparam int CNT_W = 28;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             start;
  logic             stop;
  logic             tick;
  logic             led;
  logic             running;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_en_ctrl #(.CNT_W(CNT_W), .DEF_DIV(28'd6)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .start     (start),
    .stop      (stop),
    .tick      (tick),
    .led       (led),
    .running   (running)
  );

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_cfg(input logic [CNT_W-1:0] d);
    cfg_valid = 1'b1;
    cfg_div   = d;
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cfg_valid = 1'b0; cfg_div = '0; start = 1'b0; stop = 1'b0;
    @(negedge clk);
    chk("rst tick", tick, 0);
    chk("rst led", led, 0);
    chk("rst running", running, 0);
    chk("rst cfg_ready", cfg_ready, 1);
    rst = 1'b1;
    cyc();
    chk("idle tick", tick, 0);

    // Ratio 4: ticks on edges 4, 8, 12; led 0->1 at 4, 1->0 at 8
    load_cfg(28'd4);
    do_start();
    chk("A running", running, 1);
    chk("A tick e0", tick, 0);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk($sformatf("A tick e%0d", k), tick, (k % 4 == 0) ? 1 : 0);
      if (k == 4) chk("A led e4", led, 1);
      if (k == 8) chk("A led e8", led, 0);
    end
    do_stop();
    chk("A stop running", running, 0);
    chk("A stop tick", tick, 0);
    chk("A stop led held", led, 1);

    // Ratio 4, ratio 2 transferred on edge 6: ticks at 4, 8, 10, 12
    do_start();
    for (int k = 1; k <= 12; k++) begin
      if (k == 6) begin
        cfg_valid = 1'b1;
        cfg_div   = 28'd2;
      end
      cyc();
      cfg_valid = 1'b0;
      chk($sformatf("B tick e%0d", k), tick,
          (k == 4 || k == 8 || k == 10 || k == 12) ? 1 : 0);
      chk($sformatf("B cfg_ready e%0d", k), cfg_ready, (k == 6 || k == 7) ? 0 : 1);
    end
    do_stop();

    // Ratio 0 behaves as 1: tick every cycle, led toggles every cycle
    load_cfg(28'd0);
    do_start();
    chk("C tick e0", tick, 0);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk($sformatf("C tick e%0d", k), tick, 1);
      chk($sformatf("C led e%0d", k), led, (k % 2 == 0) ? 1 : 0);
    end
    do_stop();
    chk("C stop running", running, 0);
    chk("C stop tick", tick, 0);
    chk("C stop led held", led, 1);

    // start and stop together: stop wins
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    chk("D running", running, 0);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk($sformatf("D tick e%0d", k), tick, 0);
    end

    // PEND with shadow 3, then stop: next run ticks 3 cycles after start
    load_cfg(28'd5);
    do_start();
    cyc();
    load_cfg(28'd3);
    chk("E pend running", running, 1);
    chk("E pend cfg_ready", cfg_ready, 0);
    do_stop();
    chk("E stop running", running, 0);
    chk("E stop cfg_ready", cfg_ready, 1);
    chk("E stop tick", tick, 0);
    do_start();
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk($sformatf("E tick e%0d", k), tick, (k == 3) ? 1 : 0);
    end
    // cfg and stop together in RUN: ratio 2 committed directly
    cfg_valid = 1'b1; cfg_div = 28'd2; stop = 1'b1;
    cyc();
    cfg_valid = 1'b0; stop = 1'b0;
    chk("E25 running", running, 0);
    chk("E25 cfg_ready", cfg_ready, 1);
    do_start();
    for (int k = 1; k <= 2; k++) begin
      cyc();
      chk($sformatf("E25 tick e%0d", k), tick, (k == 2) ? 1 : 0);
    end
    do_stop();
    chk("E25 led held", led, 1);

    // Asynchronous reset while in PEND with ratio 5 / shadow 3
    load_cfg(28'd5);
    do_start();
    cyc();
    load_cfg(28'd3);
    chk("F pend cfg_ready", cfg_ready, 0);
    chk("F pend running", running, 1);
    #2 rst = 1'b0;
    #1;
    chk("F async running", running, 0);
    chk("F async cfg_ready", cfg_ready, 1);
    chk("F async tick", tick, 0);
    chk("F async led", led, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk($sformatf("F idle tick %0d", k), tick, 0);
      chk($sformatf("F idle running %0d", k), running, 0);
    end
    do_start();
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk($sformatf("F tick e%0d", k), tick, (k % 6 == 0) ? 1 : 0);
      if (k == 6) chk("F led e6", led, 1);
    end
    do_stop();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
